// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXE/MEM/WB sequencing,
// PC/IR/register/memory write strobes, datapath selects and a sticky illegal flag.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        equal,
    input  logic        mem_ready,
    output logic        PCWr,
    output logic        IRWr,
    output logic [1:0]  PCOP,
    output logic [1:0]  RegDst,
    output logic [1:0]  RegWData,
    output logic        ExtOP,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [3:0]  ALUOP,
    output logic [2:0]  state,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'b000,
        DECODE = 3'b001,
        EXE    = 3'b010,
        MEM    = 3'b011,
        WB     = 3'b100
    } state_t;

    state_t cur_state, next_state;

    logic [5:0] opcode, funct;
    logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal, is_illegal;
    logic is_alu, writes_reg;
    logic pc_wr, ir_wr, reg_write, mem_write, set_illegal;
    logic [1:0] pc_op;
    logic illegal_q;
    logic unused_instr_bits;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign is_rtype = (opcode == 6'b000000);
    assign is_addu  = is_rtype && (funct == 6'b100001);
    assign is_subu  = is_rtype && (funct == 6'b100011);
    assign is_jr    = is_rtype && (funct == 6'b001000);
    assign is_ori   = (opcode == 6'b001101);
    assign is_lui   = (opcode == 6'b001111);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);
    assign is_beq   = (opcode == 6'b000100);
    assign is_j     = (opcode == 6'b000010);
    assign is_jal   = (opcode == 6'b000011);
    assign is_illegal = ~(is_addu | is_subu | is_jr | is_ori | is_lui |
                          is_lw | is_sw | is_beq | is_j | is_jal);
    assign is_alu     = is_addu | is_subu | is_ori | is_lui;
    assign writes_reg = is_alu | is_lw | is_jal;

    // Register/immediate fields are the datapath's business, not the controller's.
    assign unused_instr_bits = ^instr[25:6];

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (set_illegal)
                illegal_q <= 1'b1;
        end
    end

    // Every instruction retires (PCWr/done) in exactly the state that returns to FETCH.
    always_comb begin
        next_state  = FETCH;
        pc_wr       = 1'b0;
        ir_wr       = 1'b0;
        pc_op       = 2'b00;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        set_illegal = 1'b0;
        case (cur_state)
            FETCH: begin
                ir_wr      = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                if (is_j || is_jr) begin
                    pc_wr = 1'b1;
                    pc_op = is_jr ? 2'b10 : 2'b01;
                end else if (is_jal) begin
                    next_state = WB;
                end else if (is_illegal) begin
                    pc_wr       = 1'b1;
                    set_illegal = 1'b1;
                end else begin
                    next_state = EXE;
                end
            end
            EXE: begin
                if (is_beq) begin
                    pc_wr = 1'b1;
                    pc_op = equal ? 2'b01 : 2'b00;
                end else if (is_lw || is_sw) begin
                    next_state = MEM;
                end else if (is_alu) begin
                    next_state = WB;
                end
            end
            MEM: begin
                mem_write = is_sw;
                if (!mem_ready) begin
                    next_state = MEM;
                end else if (is_sw) begin
                    pc_wr = 1'b1;
                end else begin
                    next_state = WB;
                end
            end
            WB: begin
                pc_wr     = 1'b1;
                reg_write = writes_reg;
                pc_op     = is_jal ? 2'b01 : 2'b00;
            end
            default: next_state = FETCH;
        endcase
    end

    assign PCWr     = pc_wr & reset;
    assign done     = pc_wr & reset;
    assign IRWr     = ir_wr & reset;
    assign RegWrite = reg_write & reset;
    assign MemWrite = mem_write & reset;
    assign PCOP     = pc_op;

    assign RegDst   = {is_jal, is_ori | is_lui | is_lw};
    assign RegWData = {is_jal, is_lw};
    assign ExtOP    = is_lw | is_sw | is_beq;
    assign ALUSrc   = is_ori | is_lui | is_lw | is_sw;
    assign ALUOP    = {2'b00, is_ori | is_lui, is_lui | is_subu};

    assign state   = cur_state;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random
// instructions, checked cycle by cycle against a per-instruction-class model.
module tb_multicycle_ctrl;

    logic        clk, reset, equal, mem_ready;
    logic [31:0] instr;
    logic        PCWr, IRWr, ExtOP, ALUSrc, RegWrite, MemWrite, done, illegal;
    logic [1:0]  PCOP, RegDst, RegWData;
    logic [3:0]  ALUOP;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;
    logic ill_model = 1'b0;

    localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4;

    typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW,
                      K_BEQ, K_J, K_JAL, K_ILL} kind_t;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .equal(equal),
        .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .PCOP(PCOP),
        .RegDst(RegDst), .RegWData(RegWData), .ExtOP(ExtOP), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUOP(ALUOP),
        .state(state), .done(done), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic kind_t classify(input logic [31:0] ins);
        kind_t k;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                       6'h21:   k = K_ADDU;
                       6'h23:   k = K_SUBU;
                       6'h08:   k = K_JR;
                       default: k = K_ILL;
                   endcase
            6'h0D:   k = K_ORI;
            6'h0F:   k = K_LUI;
            6'h23:   k = K_LW;
            6'h2B:   k = K_SW;
            6'h04:   k = K_BEQ;
            6'h02:   k = K_J;
            6'h03:   k = K_JAL;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] randomInstr();
        logic [31:0] r;
        int pick;
        r = $urandom;
        pick = $urandom_range(0, 10);
        case (pick)
            0:  begin r[31:26] = 6'h00; r[5:0] = 6'h21; end
            1:  begin r[31:26] = 6'h00; r[5:0] = 6'h23; end
            2:  begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
            3:  r[31:26] = 6'h0D;
            4:  r[31:26] = 6'h0F;
            5:  r[31:26] = 6'h23;
            6:  r[31:26] = 6'h2B;
            7:  r[31:26] = 6'h04;
            8:  r[31:26] = 6'h02;
            9:  r[31:26] = 6'h03;
            default: begin
                if ($urandom_range(0, 1) == 1) r[31:26] = 6'($urandom_range(16, 31));
                else begin r[31:26] = 6'h00; r[5:0] = 6'h3F; end
            end
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkSelects(input kind_t k);
        logic [1:0] rd, rw;
        logic [3:0] aop;
        rd  = (k == K_JAL) ? 2'd2 : ((k == K_ORI || k == K_LUI || k == K_LW) ? 2'd1 : 2'd0);
        rw  = (k == K_JAL) ? 2'd2 : ((k == K_LW) ? 2'd1 : 2'd0);
        aop = (k == K_ORI) ? 4'd2 : (k == K_LUI) ? 4'd3 : (k == K_SUBU) ? 4'd1 : 4'd0;
        checkOutput("RegDst", 32'(RegDst), 32'(rd));
        checkOutput("RegWData", 32'(RegWData), 32'(rw));
        checkOutput("ExtOP", 32'(ExtOP), 32'(k == K_LW || k == K_SW || k == K_BEQ));
        checkOutput("ALUSrc", 32'(ALUSrc), 32'(k == K_ORI || k == K_LUI || k == K_LW || k == K_SW));
        checkOutput("ALUOP", 32'(ALUOP), 32'(aop));
    endtask

    // Runs one instruction from its FETCH cycle; entered and left at posedge+1.
    // rst_at >= 0 pulls reset low in that cycle and abandons the instruction.
    task automatic applyStimulus(input logic [31:0] ins, input int waits,
                                 input logic eqv, input int rst_at);
        kind_t k;
        int seq[$];
        int n, mem_seen;
        logic writes, exp_end;
        logic [1:0] exp_pcop;
        k = classify(ins);
        seq = {S_F, S_D};
        case (k)
            K_JAL: seq.push_back(S_W);
            K_BEQ: seq.push_back(S_E);
            K_ADDU, K_SUBU, K_ORI, K_LUI: begin seq.push_back(S_E); seq.push_back(S_W); end
            K_SW, K_LW: begin
                seq.push_back(S_E);
                for (int w = 0; w <= waits; w++) seq.push_back(S_M);
                if (k == K_LW) seq.push_back(S_W);
            end
            default: ;
        endcase
        n = seq.size();
        writes = (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI || k == K_LW || k == K_JAL);
        exp_pcop = (k == K_J || k == K_JAL || (k == K_BEQ && eqv)) ? 2'b01 :
                   (k == K_JR) ? 2'b10 : 2'b00;
        mem_seen = 0;
        instr = ins;
        for (int i = 0; i < n; i++) begin
            equal = (seq[i] == S_E) ? eqv : 1'($urandom);
            if (seq[i] == S_M) begin
                mem_ready = (mem_seen == waits);
                mem_seen++;
            end else begin
                mem_ready = 1'($urandom);
            end
            if (i == rst_at) begin
                reset = 1'b0;
                mem_ready = 1'b0;
                @(negedge clk);
                checkOutput("rst_state", 32'(state), 32'(seq[i]));
                checkOutput("rst_MemWrite", 32'(MemWrite), 32'd0);
                checkOutput("rst_PCWr", 32'(PCWr), 32'd0);
                checkOutput("rst_done", 32'(done), 32'd0);
                checkOutput("rst_RegWrite", 32'(RegWrite), 32'd0);
                @(posedge clk); #1;
                reset = 1'b1;
                ill_model = 1'b0;
                break;
            end
            @(negedge clk);
            exp_end = (i == n - 1);
            checkOutput("state", 32'(state), 32'(seq[i]));
            checkOutput("IRWr", 32'(IRWr), 32'(i == 0));
            checkOutput("PCWr", 32'(PCWr), 32'(exp_end));
            checkOutput("done", 32'(done), 32'(exp_end));
            checkOutput("RegWrite", 32'(RegWrite), 32'(exp_end && writes));
            checkOutput("MemWrite", 32'(MemWrite), 32'(seq[i] == S_M && k == K_SW));
            checkOutput("illegal", 32'(illegal), 32'(ill_model));
            checkSelects(k);
            if (exp_end) checkOutput("PCOP", 32'(PCOP), 32'(exp_pcop));
            @(posedge clk); #1;
            if (seq[i] == S_D && k == K_ILL) ill_model = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b0;
        instr = 32'h0;
        equal = 1'b0;
        mem_ready = 1'b0;
        $display("[TB] reset phase");
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_illegal", 32'(illegal), 32'd0);
        checkOutput("reset_IRWr", 32'(IRWr), 32'd0);
        checkOutput("reset_PCWr", 32'(PCWr), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        $display("[TB] directed scenarios");
        applyStimulus(32'h00430821, 0, 1'b0, -1);
        applyStimulus(32'h8E080004, 2, 1'b0, -1);
        applyStimulus(32'h10000003, 0, 1'b1, -1);
        applyStimulus(32'h10000003, 0, 1'b0, -1);
        applyStimulus(32'h0C000010, 0, 1'b0, -1);
        applyStimulus(32'h03E00008, 0, 1'b0, -1);
        applyStimulus(32'hAD090008, 0, 1'b0, -1);
        applyStimulus(32'hFC000000, 0, 1'b0, -1);
        applyStimulus(32'h00430821, 0, 1'b0, -1);
        applyStimulus(32'hAD090008, 3, 1'b0, 4);
        applyStimulus(32'h3C011234, 0, 1'b0, -1);

        $display("[TB] random instructions");
        for (int t = 0; t < 60; t++)
            applyStimulus(randomInstr(), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-low; it is sampled only on the rising edge of clk.
REQ-003 SHALL have port instr, input, 32 bits: current instruction register contents; opcode is [31:26], funct is [5:0].
REQ-004 SHALL have port equal, input, 1 bit: datapath comparison result (rs==rt), sampled in EXE.
REQ-005 SHALL have port mem_ready, input, 1 bit: data memory handshake; when high, the current access completes this cycle.
REQ-006 SHALL have ports PCWr and IRWr, outputs, 1 bit each: write enables for the PC and the instruction register.
REQ-007 SHALL have port PCOP, output, 2 bits: 00 = PC+4, 01 = NPC (beq target, or j/jal target), 10 = register rs (jr).
REQ-008 SHALL have port RegDst, output, 2 bits: 00 = rd, 01 = rt, 10 = $31.
REQ-009 SHALL have port RegWData, output, 2 bits: 00 = ALU result, 01 = DM data, 10 = PC+4.
REQ-010 SHALL have ports ExtOP, ALUSrc, RegWrite and MemWrite, outputs, 1 bit each: ExtOP 1 = sign-extend and 0 = zero-extend; ALUSrc 1 = immediate.
REQ-011 SHALL have port ALUOP, output, 4 bits: 0000 = add, 0001 = sub, 0010 = or, 0011 = lui.
REQ-012 SHALL have ports state, output, 3 bits, and done, output, 1 bit: state is the current FSM state; done is the instruction-retire pulse.
REQ-013 SHALL have port illegal, output, 1 bit: sticky flag indicating that an undecodable instruction was seen.

Function
REQ-014 SHALL implement FSM states FETCH = 000, DECODE = 001, EXE = 010, MEM = 011 and WB = 100; other codes SHALL go to FETCH on the next edge.
REQ-015 SHALL decode addu (op 0, funct 100001), subu (op 0, funct 100011), jr (op 0, funct 001000), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100), j (000010) and jal (000011); every other encoding is illegal.
REQ-016 SHALL assert IRWr in FETCH only; FETCH SHALL always go to DECODE.
REQ-017 SHALL make the DECODE transitions as follows:
- j and jr: go to FETCH.
- jal: go to WB.
- illegal: set illegal and go to FETCH.
- all other instructions: go to EXE.
REQ-018 SHALL make the EXE transitions as follows: addu, subu, ori and lui go to WB; lw and sw go to MEM; beq goes to FETCH.
REQ-019 SHALL hold in MEM while mem_ready=0; when mem_ready=1, lw SHALL go to WB and sw SHALL go to FETCH.
REQ-020 SHALL make WB always go to FETCH.
REQ-021 SHALL assert PCWr for exactly one cycle per instruction, in the instruction's final state, with PCOP set as follows:
- j and jal: 01.
- jr: 10.
- beq: 01 if equal=1, else 00.
- all others: 00.
- illegal: 00, in DECODE.
REQ-022 SHALL assert done in the same cycle as PCWr.
REQ-023 SHALL assert RegWrite only in WB, for addu, subu, ori, lui, lw and jal.
REQ-024 SHALL assert MemWrite only in MEM, for sw, in every cycle of the wait, including the completing cycle.
REQ-025 SHALL drive the datapath selects from instr in every state (combinational from instr and state):
- RegDst = {jal, ori|lui|lw}.
- RegWData = {jal, lw}.
- ExtOP = lw|sw|beq.
- ALUSrc = ori|lui|lw|sw.
- ALUOP = {2'b00, ori|lui, lui|subu}.
REQ-026 SHALL give the following instruction latencies, counted as clk cycles from FETCH to done inclusive:
- j and jr: 2.
- jal and beq: 3.
- addu, subu, ori, lui and sw: 4 (sw when mem_ready is immediate).
- lw: 5 when mem_ready is immediate.
- lw and sw SHALL add one cycle per MEM wait cycle.
REQ-027 SHALL keep illegal set until reset; once set, illegal SHALL NOT change sequencing.
REQ-028 SHALL ignore instr changes outside DECODE/EXE/MEM/WB decode use (the IR is stable after FETCH); SHALL ignore equal outside EXE; SHALL ignore mem_ready outside MEM.

Reset
REQ-029 SHALL, on a rising edge with reset=0, set state to FETCH and clear illegal, regardless of the current state, including mid-MEM wait.
REQ-030 SHALL force PCWr, IRWr, RegWrite, MemWrite and done to 0 during any cycle in which reset=0.
REQ-031 SHALL assert IRWr in the first cycle after reset is released.

Verification
REQ-032 SHALL cover this scenario: instr 0x00430821 (addu $1, $2, $3) -> states 000, 001, 010, 100; RegWrite=1 with RegDst=00 and RegWData=00 in WB; PCWr=1 with PCOP=00 and done=1 in WB.
REQ-033 SHALL cover this scenario: instr 0x8E080004 (lw) with mem_ready held 0 for 2 cycles -> MEM lasts 3 cycles; WB with RegDst=01, RegWData=01, ExtOP=1; 7 cycles total.
REQ-034 SHALL cover this scenario: instr 0x10000003 (beq) with equal=1 -> PCWr in EXE with PCOP=01; repeated with equal=0 -> PCOP=00; 3 cycles, no RegWrite.
REQ-035 SHALL cover this scenario: instr 0x0C000010 (jal) -> WB with RegDst=10, RegWData=10, PCOP=01; 3 cycles; then 0x03E00008 (jr) -> PCOP=10 in DECODE; 2 cycles.
REQ-036 SHALL cover this scenario: instr 0xFC000000 (illegal) -> illegal=1 after DECODE, no RegWrite/MemWrite, PCOP=00; illegal stays 1 through the next addu.
REQ-037 SHALL cover this scenario: sw with reset=0 asserted while in MEM with mem_ready=0 -> MemWrite=0 in that cycle; state=000 on the next edge; illegal=0.
